// File: rtl/serial_cmp_cascade.sv
// Digit-serial magnitude comparator with 7485-style cascade inputs.
// Processes one 4-bit digit per clock, least significant first, so the top digit has the final say.
module serial_cmp_cascade #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a_in,
  input  logic [4*NIBBLES-1:0] b_in,
  input  logic                 ia_lt_b,
  input  logic                 ia_eq_b,
  input  logic                 ia_gt_b,
  output logic                 busy,
  output logic                 done,
  output logic                 oa_lt_b,
  output logic                 oa_eq_b,
  output logic                 oa_gt_b
);

  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMP  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]      r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [IDXW-1:0] r_idx;
  logic            r_eq;
  logic            r_gt;
  logic            r_lt;
  logic            r_oaLt;
  logic            r_oaEq;
  logic            r_oaGt;

  logic [3:0] w_aDig;
  logic [3:0] w_bDig;
  logic       w_digEq;
  logic       w_digGt;
  logic       w_digLt;
  logic       w_eqNext;
  logic       w_gtNext;
  logic       w_ltNext;

  assign w_aDig  = 4'(r_a >> {r_idx, 2'b00});
  assign w_bDig  = 4'(r_b >> {r_idx, 2'b00});
  assign w_digEq = (w_aDig == w_bDig);
  assign w_digGt = (w_aDig > w_bDig);
  assign w_digLt = (w_aDig < w_bDig);

  // A differing digit overrides everything below it; an equal digit passes the lower verdict up.
  assign w_eqNext = w_digEq & r_eq;
  assign w_gtNext = w_digGt | (w_digEq & r_gt);
  assign w_ltNext = w_digLt | (w_digEq & r_lt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      r_eq    <= 1'b0;
      r_gt    <= 1'b0;
      r_lt    <= 1'b0;
      r_oaLt  <= 1'b0;
      r_oaEq  <= 1'b0;
      r_oaGt  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= a_in;
            r_b     <= b_in;
            r_idx   <= '0;
            r_eq    <= ia_eq_b;
            r_gt    <= ~(ia_lt_b | ia_eq_b);
            r_lt    <= ~(ia_gt_b | ia_eq_b);
            r_state <= ST_CMP;
          end
        end
        ST_CMP: begin
          r_eq <= w_eqNext;
          r_gt <= w_gtNext;
          r_lt <= w_ltNext;
          // The last digit's verdict goes straight to the outputs so DONE follows without a gap.
          if (r_idx == LAST_IDX) begin
            r_oaLt  <= w_ltNext;
            r_oaEq  <= w_eqNext;
            r_oaGt  <= w_gtNext;
            r_state <= ST_DONE;
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = (r_state != ST_IDLE);
  assign done    = (r_state == ST_DONE);
  assign oa_lt_b = r_oaLt;
  assign oa_eq_b = r_oaEq;
  assign oa_gt_b = r_oaGt;

endmodule

// File: tb/tb_serial_cmp_cascade.sv
// Directed bench for serial_cmp_cascade: table of operand/cascade vectors plus
// hand-written sequences for back-to-back starts, ignored starts and mid-operation reset.
module tb_serial_cmp_cascade;

  localparam int NIBBLES = 4;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        ia_lt_b;
  logic        ia_eq_b;
  logic        ia_gt_b;
  logic        busy;
  logic        done;
  logic        oa_lt_b;
  logic        oa_eq_b;
  logic        oa_gt_b;

  int nCompared;
  int nMismatch;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic        cLt;
    logic        cEq;
    logic        cGt;
    logic        eLt;
    logic        eEq;
    logic        eGt;
  } vec_t;

  vec_t vecs[11];

  serial_cmp_cascade #(.NIBBLES(NIBBLES)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .ia_lt_b (ia_lt_b),
    .ia_eq_b (ia_eq_b),
    .ia_gt_b (ia_gt_b),
    .busy    (busy),
    .done    (done),
    .oa_lt_b (oa_lt_b),
    .oa_eq_b (oa_eq_b),
    .oa_gt_b (oa_gt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one comparison; inputs are scrambled right after acceptance to show they are not resampled.
  task automatic applyStimulus(input vec_t v);
    int n;
    @(negedge clk);
    a_in    = v.a;
    b_in    = v.b;
    ia_lt_b = v.cLt;
    ia_eq_b = v.cEq;
    ia_gt_b = v.cGt;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    a_in    = ~v.a;
    b_in    = v.a;
    ia_lt_b = ~v.cLt;
    ia_eq_b = ~v.cEq;
    ia_gt_b = ~v.cGt;
    n = 1;
    checkOutput({v.name, " busy_after_start"}, 32'(busy), 32'd1);
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput({v.name, " done_latency"}, 32'(n), 32'(NIBBLES + 1));
    checkOutput({v.name, " result_lt_eq_gt"}, {29'd0, oa_lt_b, oa_eq_b, oa_gt_b},
                {29'd0, v.eLt, v.eEq, v.eGt});
    @(negedge clk);
    checkOutput({v.name, " idle_busy_done"}, {30'd0, busy, done}, 32'd0);
    checkOutput({v.name, " result_held"}, {29'd0, oa_lt_b, oa_eq_b, oa_gt_b},
                {29'd0, v.eLt, v.eEq, v.eGt});
  endtask

  initial begin
    int doneCnt;
    int dPos[3];

    nCompared = 0;
    nMismatch = 0;

    vecs[0]  = '{"lsd_lt",      16'h1234, 16'h1235, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{"msd_decides", 16'hA000, 16'h0FFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{"eq_casc_lt",  16'h5A5A, 16'h5A5A, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{"eq_casc_gt",  16'h5A5A, 16'h5A5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{"eq_casc_eq",  16'h5A5A, 16'h5A5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{"casc_zero",   16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{"casc_ones",   16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{"max_vs_zero", 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{"zero_vs_max", 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{"lsd_gt_clt",  16'h1235, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{"eq_dominant", 16'h1111, 16'h1111, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    rst     = 1'b1;
    start   = 1'b0;
    a_in    = '0;
    b_in    = '0;
    ia_lt_b = 1'b0;
    ia_eq_b = 1'b0;
    ia_gt_b = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_state", {27'd0, busy, done, oa_lt_b, oa_eq_b, oa_gt_b}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) applyStimulus(vecs[i]);

    // start held high: acceptance edges 0, 6, 12, 18 give done at sample cycles 4, 10, 16
    @(negedge clk);
    a_in    = 16'h0002;
    b_in    = 16'h0001;
    ia_lt_b = 1'b0;
    ia_eq_b = 1'b1;
    ia_gt_b = 1'b0;
    start   = 1'b1;
    doneCnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) begin
        if (doneCnt < 3) dPos[doneCnt] = c;
        doneCnt++;
      end
    end
    start = 1'b0;
    checkOutput("b2b_done_count", 32'(doneCnt), 32'd3);
    checkOutput("b2b_first_done", 32'(dPos[0]), 32'd4);
    checkOutput("b2b_second_done", 32'(dPos[1]), 32'd10);
    checkOutput("b2b_third_done", 32'(dPos[2]), 32'd16);
    checkOutput("b2b_result", {29'd0, oa_lt_b, oa_eq_b, oa_gt_b}, 32'b001);
    repeat (10) @(negedge clk);
    checkOutput("b2b_drained", 32'(busy), 32'd0);

    // start pulse during CMP must not be queued
    @(negedge clk);
    a_in    = 16'h0001;
    b_in    = 16'h0002;
    ia_lt_b = 1'b0;
    ia_eq_b = 1'b1;
    ia_gt_b = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    doneCnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) doneCnt++;
    end
    checkOutput("midcmp_start_done_count", 32'(doneCnt), 32'd1);
    checkOutput("midcmp_start_result", {29'd0, oa_lt_b, oa_eq_b, oa_gt_b}, 32'b100);

    // reset on the third CMP cycle aborts the operation and clears the outputs
    applyStimulus(vecs[1]);
    @(negedge clk);
    a_in    = 16'h1234;
    b_in    = 16'h1235;
    ia_lt_b = 1'b0;
    ia_eq_b = 1'b1;
    ia_gt_b = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_state", {27'd0, busy, done, oa_lt_b, oa_eq_b, oa_gt_b}, 32'd0);
    rst = 1'b0;
    doneCnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done) doneCnt++;
    end
    checkOutput("abort_no_done", 32'(doneCnt), 32'd0);
    applyStimulus(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
